// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// mem_ctrl_if : pipeline request/response and byte-RAM bus of mem_ctrl
// Revision    : 1.0
// ============================================================================
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic [31:0]           if_inst;

  logic                  mem_load;
  logic                  mem_store;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [1:0]            mem_size;
  logic                  mem_signed;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_wr;
  logic [7:0]            ram_dout;
  logic [7:0]            ram_din;

  logic                  stallreq_if;
  logic                  stallreq_mem;

  modport master (
    output if_req, if_addr, mem_load, mem_store, mem_addr, mem_wdata,
           mem_size, mem_signed, ram_din,
    input  if_ready, if_inst, mem_ready, mem_rdata, ram_addr, ram_wr,
           ram_dout, stallreq_if, stallreq_mem
  );

  modport slave (
    input  if_req, if_addr, mem_load, mem_store, mem_addr, mem_wdata,
           mem_size, mem_signed, ram_din,
    output if_ready, if_inst, mem_ready, mem_rdata, ram_addr, ram_wr,
           ram_dout, stallreq_if, stallreq_mem
  );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// mem_ctrl : IF/MEM arbiter sequencing 8/16/32-bit accesses as byte transfers
// Revision : 1.0
// ============================================================================
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter bit MEM_FIRST  = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q;
  logic [2:0]            cnt_q;
  logic [2:0]            nbytes_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [31:0]           buf_q;
  logic [1:0]            size_q;
  logic                  sign_q;
  logic                  owner_mem_q;

  logic                  if_ready_q;
  logic [31:0]           if_inst_q;
  logic                  mem_ready_q;
  logic [31:0]           mem_rdata_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  ram_wr_q;
  logic [7:0]            ram_dout_q;

  logic                  mem_pend;
  logic                  grant_mem;
  logic                  grant_if;
  logic [2:0]            acc_nbytes_d;
  logic [ADDR_WIDTH-1:0] acc_addr_d;
  logic [2:0]            cnt_d;
  logic [31:0]           buf_d;
  logic                  rd_last;
  logic                  wr_last;
  logic [ADDR_WIDTH-1:0] rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    byte_sel = w[{i, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] b, input logic [1:0] sz,
                                         input logic sg);
    case (sz)
      2'd0:    extend = {{24{sg & b[7]}}, b[7:0]};
      2'd1:    extend = {{16{sg & b[15]}}, b[15:0]};
      default: extend = b;
    endcase
  endfunction

  // Tie-break only matters when both requesters are pending in the same IDLE cycle.
  assign mem_pend  = bus.mem_load | bus.mem_store;
  assign grant_mem = MEM_FIRST ? mem_pend : (mem_pend & ~bus.if_req);
  assign grant_if  = bus.if_req & ~grant_mem;

  assign acc_addr_d   = grant_if ? bus.if_addr : bus.mem_addr;
  assign acc_nbytes_d = grant_if                 ? 3'd4 :
                        (bus.mem_size == 2'd0)   ? 3'd1 :
                        (bus.mem_size == 2'd1)   ? 3'd2 : 3'd4;

  assign cnt_d     = cnt_q + 3'd1;
  assign rd_last   = (cnt_q == nbytes_q);
  assign wr_last   = (cnt_q == nbytes_q - 3'd1);
  assign wr_addr_d = base_q + ADDR_WIDTH'(cnt_d);
  assign rd_addr_d = (cnt_d < nbytes_q) ? wr_addr_d : '0;

  // RAM data lags its address by one cycle, so count c lands byte c-1.
  always_comb begin
    buf_d = buf_q;
    case (cnt_q)
      3'd1:    buf_d[7:0]   = bus.ram_din;
      3'd2:    buf_d[15:8]  = bus.ram_din;
      3'd3:    buf_d[23:16] = bus.ram_din;
      3'd4:    buf_d[31:24] = bus.ram_din;
      default: buf_d = buf_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      owner_mem_q <= 1'b0;
      if_ready_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_mem | grant_if) begin
            base_q      <= acc_addr_d;
            nbytes_q    <= acc_nbytes_d;
            size_q      <= grant_if ? 2'd2 : bus.mem_size;
            sign_q      <= grant_mem & bus.mem_signed;
            wdata_q     <= bus.mem_wdata;
            owner_mem_q <= grant_mem;
            cnt_q       <= '0;
            buf_q       <= '0;
            ram_addr_q  <= acc_addr_d;
            if (grant_mem & bus.mem_store) begin
              state_q    <= S_WR;
              ram_wr_q   <= 1'b1;
              ram_dout_q <= bus.mem_wdata[7:0];
            end else begin
              state_q <= S_RD;
            end
          end
        end

        S_RD: begin
          buf_q      <= buf_d;
          cnt_q      <= cnt_d;
          ram_addr_q <= rd_addr_d;
          if (rd_last) begin
            state_q <= S_DONE;
            if (owner_mem_q) begin
              mem_ready_q <= 1'b1;
              mem_rdata_q <= extend(buf_d, size_q, sign_q);
            end else begin
              if_ready_q <= 1'b1;
              if_inst_q  <= buf_d;
            end
          end
        end

        S_WR: begin
          cnt_q <= cnt_d;
          if (wr_last) begin
            state_q     <= S_DONE;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_dout_q  <= '0;
            mem_ready_q <= 1'b1;
            mem_rdata_q <= '0;
          end else begin
            ram_addr_q <= wr_addr_d;
            ram_dout_q <= byte_sel(wdata_q, cnt_d[1:0]);
          end
        end

        S_DONE: begin
          if_ready_q  <= 1'b0;
          mem_ready_q <= 1'b0;
          state_q     <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.if_ready     = if_ready_q;
  assign bus.if_inst      = if_inst_q;
  assign bus.mem_ready    = mem_ready_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_wr       = ram_wr_q;
  assign bus.ram_dout     = ram_dout_q;
  assign bus.stallreq_mem = mem_pend & ~mem_ready_q;
  assign bus.stallreq_if  = bus.if_req & ~if_ready_q;

endmodule
`default_nettype wire
